// File: rtl/column_feeder_if.sv
// Column stream handshake between a producer and the column feeder.
// Ports: s_valid/s_data from master, s_ready from slave.
interface column_feeder_if #(
  parameter int BUF_HEIGHT = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [BUF_HEIGHT-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );
endinterface

// File: rtl/column_feeder.sv
// Stages pixel columns in a FIFO and feeds the column shift buffer.
// Ports: clk, rst, start, img_width, num_strips, s_if (column stream),
//   stall, pixel_out, shift_enable, strip_end, done, busy.
module column_feeder #(
  parameter int BUF_HEIGHT = 8,
  parameter int BUF_WIDTH  = 34,
  parameter int FIFO_DEPTH = 4,
  parameter int STRIP_W    = 8,
  localparam int WW        = $clog2(BUF_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WW-1:0]         img_width,
  input  logic [STRIP_W-1:0]    num_strips,
  column_feeder_if.slave        s_if,
  input  logic                  stall,
  output logic [BUF_HEIGHT-1:0] pixel_out,
  output logic                  shift_enable,
  output logic                  strip_end,
  output logic                  done,
  output logic                  busy
);
  localparam int CW = WW + STRIP_W;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WW-1:0]         w_q;
  logic [STRIP_W-1:0]    ns_q;
  logic [CW-1:0]         in_cnt_q;
  logic [WW-1:0]         col_cnt_q;
  logic [STRIP_W-1:0]    strip_cnt_q;
  logic [BUF_HEIGHT-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_q, rd_q;

  logic          run, go, cfg_ok;
  logic          full, empty;
  logic          push, pop;
  logic          last_col, last;
  logic [CW-1:0] total;
  logic          ready;

  assign run    = (state_q == RUN);
  assign go     = start && !run;
  assign cfg_ok = (img_width != '0) && (num_strips != '0);
  assign total  = CW'(w_q) * CW'(ns_q);

  // Wrap bit distinguishes full from empty when indices match.
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign last_col = (col_cnt_q == w_q - WW'(1));
  assign last     = last_col &&
                    (strip_cnt_q == ns_q - STRIP_W'(1));

  assign push = s_if.s_valid && ready;
  assign pop  = shift_enable;

  assign s_if.s_ready = ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = cfg_ok ? RUN : DONE;
        end
      end
      RUN: begin
        if (pop && last) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready        = run && !full && (in_cnt_q < total);
    shift_enable = run && !empty && !stall;
    pixel_out    = '0;
    if (shift_enable) begin
      pixel_out = mem_q[rd_q[AW-1:0]];
    end
    strip_end = shift_enable && last_col;
    done      = (state_q == DONE);
    busy      = run;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      ns_q        <= '0;
      in_cnt_q    <= '0;
      col_cnt_q   <= '0;
      strip_cnt_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (go) begin
      w_q         <= img_width;
      ns_q        <= num_strips;
      in_cnt_q    <= '0;
      col_cnt_q   <= '0;
      strip_cnt_q <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= s_if.s_data;
        wr_q     <= wr_q + (AW+1)'(1);
        in_cnt_q <= in_cnt_q + CW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + (AW+1)'(1);
        if (last_col) begin
          col_cnt_q   <= '0;
          strip_cnt_q <= strip_cnt_q + STRIP_W'(1);
        end else begin
          col_cnt_q <= col_cnt_q + WW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_column_feeder.sv
// Testbench for column_feeder: queue-based reference model plus
// directed scenarios with literal expectations.
module tb_column_feeder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [5:0] img_width = '0;
  logic [7:0] num_strips = '0;
  logic [7:0] pixel_out;
  logic       shift_enable, strip_end, done, busy;
  logic [7:0] xfer_cnt = '0;

  int checks = 0;
  int errors = 0;

  column_feeder_if #(.BUF_HEIGHT(8)) bus ();

  column_feeder #(
    .BUF_HEIGHT(8),
    .BUF_WIDTH (34),
    .FIFO_DEPTH(4),
    .STRIP_W   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .img_width   (img_width),
    .num_strips  (num_strips),
    .s_if        (bus),
    .stall       (stall),
    .pixel_out   (pixel_out),
    .shift_enable(shift_enable),
    .strip_end   (strip_end),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Column k of an image (1-based) carries value k.
  always @(posedge clk) begin
    if (rst || start) begin
      xfer_cnt <= '0;
    end else if (bus.s_valid && bus.s_ready) begin
      xfer_cnt <= xfer_cnt + 8'd1;
    end
  end

  always_comb bus.s_data = xfer_cnt + 8'd1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: image-level view of the feeder.
  logic [7:0] q [$];
  bit         m_run  = 0;
  bit         m_done = 0;
  int         m_w = 0, m_ns = 0, m_total = 0;
  int         m_acc = 0, m_emit = 0;
  bit         armed = 0;

  // Observations used by the directed checks.
  int         cyc = 0;
  int         start_cyc = 0;
  int         se_cnt = 0;
  int         acc_cnt = 0;
  int         first_se = -1;
  int         last_se = -1;
  int         done_cyc = -1;
  logic [31:0] end_mask = '0;
  logic [7:0] pix_log [$];

  always @(negedge clk) begin
    bit e_rdy, e_se, e_end;
    int e_pix;
    cyc++;
    e_rdy = m_run && q.size() < 4 && m_acc < m_total;
    e_se  = m_run && q.size() != 0 && !stall;
    e_pix = e_se ? int'(q[0]) : 0;
    e_end = e_se && m_w != 0 && (m_emit % m_w == m_w - 1);
    if (armed) begin
      chk("s_ready", int'(bus.s_ready), int'(e_rdy));
      chk("shift_enable", int'(shift_enable), int'(e_se));
      chk("pixel_out", int'(pixel_out), e_pix);
      chk("strip_end", int'(strip_end), int'(e_end));
      chk("done", int'(done), int'(m_done));
      chk("busy", int'(busy), int'(m_run));
      chk("done_se_excl", int'(done && shift_enable), 0);
    end
    if (start) begin
      start_cyc = cyc;
      se_cnt = 0;
      acc_cnt = 0;
      first_se = -1;
      last_se = -1;
      done_cyc = -1;
      end_mask = '0;
      pix_log.delete();
    end
    if (bus.s_valid && bus.s_ready) acc_cnt++;
    if (shift_enable) begin
      se_cnt++;
      if (first_se < 0) first_se = cyc;
      last_se = cyc;
      if (strip_end && se_cnt < 32) end_mask[se_cnt] = 1'b1;
      pix_log.push_back(pixel_out);
    end
    if (done && done_cyc < 0) done_cyc = cyc;

    if (rst) begin
      m_run = 0;
      m_done = 0;
      m_acc = 0;
      m_emit = 0;
      m_total = 0;
      q.delete();
      armed = 1;
    end else if (start && !m_run) begin
      m_w = int'(img_width);
      m_ns = int'(num_strips);
      m_total = m_w * m_ns;
      m_acc = 0;
      m_emit = 0;
      q.delete();
      m_run = (m_total != 0);
      m_done = (m_total == 0);
    end else if (m_run) begin
      if (e_se) begin
        void'(q.pop_front());
        m_emit++;
        if (m_emit == m_total) begin
          m_run = 0;
          m_done = 1;
        end
      end
      if (e_rdy && bus.s_valid) begin
        q.push_back(bus.s_data);
        m_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_image(int w, int ns);
    img_width = 6'(w);
    num_strips = 8'(ns);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(done), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_valid = 1'b1;
    rst = 1'b1;
    tick();
    tick();
    chk("t1_ready", int'(bus.s_ready), 0);
    chk("t1_se", int'(shift_enable), 0);
    chk("t1_pix", int'(pixel_out), 0);
    chk("t1_done", int'(done), 0);
    rst = 1'b0;
    tick();

    begin_image(5, 2);
    wait_done("t2_done", 100);
    tick();
    chk("t2_pulses", se_cnt, 10);
    chk("t2_strip_end", int'(end_mask), 32'h420);
    chk("t2_first_lat", first_se - start_cyc, 2);
    chk("t2_done_lat", done_cyc - last_se, 1);

    stall = 1'b1;
    begin_image(5, 2);
    repeat (20) tick();
    chk("t3_accepts", acc_cnt, 4);
    chk("t3_no_se", se_cnt, 0);
    chk("t3_ready", int'(bus.s_ready), 0);
    stall = 1'b0;
    wait_done("t3_done", 100);
    tick();
    chk("t3_count", pix_log.size(), 10);
    for (int i = 0; i < pix_log.size() && i < 10; i++) begin
      chk("t3_order", int'(pix_log[i]), i + 1);
    end

    begin_image(3, 1);
    repeat (30) tick();
    chk("t4_accepts", acc_cnt, 3);
    chk("t4_done", int'(done), 1);
    chk("t4_ready", int'(bus.s_ready), 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_idle_done", int'(done), 0);
    begin_image(0, 4);
    chk("t5_zero_done", int'(done), 1);
    chk("t5_zero_busy", int'(busy), 0);
    tick();
    chk("t5_zero_se", se_cnt, 0);
    bus.s_valid = 1'b0;
    begin_image(4, 1);
    tick();
    begin_image(0, 1);
    chk("t5_ign_busy", int'(busy), 1);
    chk("t5_ign_done", int'(done), 0);
    bus.s_valid = 1'b1;
    wait_done("t5_done", 100);
    tick();
    chk("t5_pulses", se_cnt, 4);

    begin_image(5, 2);
    begin
      int n = 0;
      while (acc_cnt < 4 && n < 50) begin
        tick();
        n++;
      end
    end
    chk("t6_mid", acc_cnt, 4);
    rst = 1'b1;
    tick();
    chk("t6_ready", int'(bus.s_ready), 0);
    chk("t6_se", int'(shift_enable), 0);
    chk("t6_pix", int'(pixel_out), 0);
    chk("t6_done", int'(done), 0);
    chk("t6_busy", int'(busy), 0);
    rst = 1'b0;
    tick();
    begin_image(2, 1);
    wait_done("t6_done2", 100);
    tick();
    chk("t6_pulses", se_cnt, 2);
    chk("t6_cnt", pix_log.size(), 2);
    if (pix_log.size() == 2) begin
      chk("t6_col0", int'(pix_log[0]), 1);
      chk("t6_col1", int'(pix_log[1]), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
